// File: rtl/irda_fast_enable_gen_multi.sv
// Fractional-N base tick generator for the IrDA MIR/FIR paths, with NDIV
// programmable TX/RX sub-dividers, glitch-free ratio reload and RX re-phasing.
module irda_fast_enable_gen_multi #(
  parameter int MULT      = 100000,
  parameter int CDR_WIDTH = 24,
  parameter int BUS_CLOCK = 200,
  parameter int BASE_MHZ  = 40,
  parameter int NDIV      = 3,
  parameter int DIV_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      wb_rst_n,
  input  logic                      enable,
  input  logic [CDR_WIDTH-1:0]      f_cdr,
  input  logic                      cdr_load,
  output logic                      cdr_ack,
  output logic                      cdr_err,
  input  logic                      tx_select,
  input  logic                      loopback_enable,
  input  logic [NDIV-1:0]           div_en,
  input  logic [NDIV*DIV_WIDTH-1:0] div_tc,
  input  logic                      rx_resync,
  output logic                      fast_enable,
  output logic [NDIV-1:0]           tx_tick,
  output logic [NDIV-1:0]           rx_tick
);

  localparam logic [CDR_WIDTH-1:0] LP_MULT      = CDR_WIDTH'(MULT);
  localparam logic [CDR_WIDTH-1:0] LP_RESET_CDR = CDR_WIDTH'((BUS_CLOCK / BASE_MHZ) * MULT);
  localparam logic [DIV_WIDTH-1:0] LP_ONE       = DIV_WIDTH'(1);

  logic [CDR_WIDTH-1:0] r_acc;
  logic [CDR_WIDTH-1:0] r_cur_cdr;
  logic [CDR_WIDTH-1:0] r_pend;
  logic                 r_pend_valid;
  logic                 r_fast_enable;
  logic                 r_cdr_ack;
  logic                 r_cdr_err;
  logic [DIV_WIDTH-1:0] r_tx_cnt [NDIV];
  logic [DIV_WIDTH-1:0] r_rx_cnt [NDIV];
  logic [NDIV-1:0]      r_tx_tick;
  logic [NDIV-1:0]      r_rx_tick;

  logic                 w_load_ok;
  logic                 w_load_bad;
  logic                 w_fire;
  logic [CDR_WIDTH-1:0] w_next_cdr;
  logic                 w_ftx;
  logic                 w_frx;
  logic [DIV_WIDTH-1:0] w_tc [NDIV];

  // A ratio of one base period or less could never let the accumulator count down.
  assign w_load_ok  = cdr_load && (f_cdr > LP_MULT);
  assign w_load_bad = cdr_load && !(f_cdr > LP_MULT);
  assign w_fire     = (r_acc <= LP_MULT);
  assign w_next_cdr = r_pend_valid ? r_pend : r_cur_cdr;

  // Held-off enable keeps counters frozen on the first disabled cycle too.
  assign w_ftx = r_fast_enable & enable & (loopback_enable | tx_select);
  assign w_frx = r_fast_enable & enable & (loopback_enable | ~tx_select);

  for (genvar g = 0; g < NDIV; g++) begin : g_tc
    assign w_tc[g] = div_tc[g*DIV_WIDTH +: DIV_WIDTH];
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_acc         <= LP_RESET_CDR;
      r_cur_cdr     <= LP_RESET_CDR;
      r_pend        <= '0;
      r_pend_valid  <= 1'b0;
      r_fast_enable <= 1'b0;
      r_cdr_ack     <= 1'b0;
      r_cdr_err     <= 1'b0;
    end else begin
      r_cdr_ack <= 1'b0;
      r_cdr_err <= w_load_bad;
      if (!enable) begin
        r_fast_enable <= 1'b0;
        if (w_load_ok) begin
          r_cur_cdr    <= f_cdr;
          r_acc        <= f_cdr;
          r_pend_valid <= 1'b0;
          r_cdr_ack    <= 1'b1;
        end else begin
          r_acc <= r_cur_cdr;
        end
      end else begin
        if (w_load_ok) begin
          r_pend       <= f_cdr;
          r_pend_valid <= 1'b1;
        end
        if (w_fire) begin
          r_fast_enable <= 1'b1;
          r_acc         <= r_acc + w_next_cdr - LP_MULT;
          // A load arriving on the application cycle stays pending for the next tick.
          if (r_pend_valid) begin
            r_cur_cdr <= r_pend;
            r_cdr_ack <= 1'b1;
            if (!w_load_ok) begin
              r_pend_valid <= 1'b0;
            end
          end
        end else begin
          r_fast_enable <= 1'b0;
          r_acc         <= r_acc - LP_MULT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_tx_tick <= '0;
      r_rx_tick <= '0;
      for (int i = 0; i < NDIV; i++) begin
        r_tx_cnt[i] <= '0;
        r_rx_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NDIV; i++) begin
        if (!div_en[i]) begin
          r_tx_cnt[i]  <= w_tc[i];
          r_tx_tick[i] <= 1'b0;
        end else if (w_ftx) begin
          if (r_tx_cnt[i] == '0) begin
            r_tx_tick[i] <= 1'b1;
            r_tx_cnt[i]  <= w_tc[i];
          end else begin
            r_tx_tick[i] <= 1'b0;
            r_tx_cnt[i]  <= r_tx_cnt[i] - LP_ONE;
          end
        end else begin
          r_tx_tick[i] <= 1'b0;
        end

        // Resync lands the RX counter at mid-bit and wins over any base tick.
        if (!div_en[i]) begin
          r_rx_cnt[i]  <= w_tc[i];
          r_rx_tick[i] <= 1'b0;
        end else if (rx_resync) begin
          r_rx_cnt[i]  <= w_tc[i] >> 1;
          r_rx_tick[i] <= 1'b0;
        end else if (w_frx) begin
          if (r_rx_cnt[i] == '0) begin
            r_rx_tick[i] <= 1'b1;
            r_rx_cnt[i]  <= w_tc[i];
          end else begin
            r_rx_tick[i] <= 1'b0;
            r_rx_cnt[i]  <= r_rx_cnt[i] - LP_ONE;
          end
        end else begin
          r_rx_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign fast_enable = r_fast_enable;
  assign cdr_ack     = r_cdr_ack;
  assign cdr_err     = r_cdr_err;
  assign tx_tick     = r_tx_tick;
  assign rx_tick     = r_rx_tick;

endmodule

// File: tb/tb_irda_fast_enable_gen_multi.sv
// Directed bench for irda_fast_enable_gen_multi: a per-cycle vector table for the
// accumulator and ratio loading, then hand sequences for dividers, resync and reset.
module tb_irda_fast_enable_gen_multi;

  localparam int CW = 24;
  localparam int ND = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          wbRstN;
  logic          enable;
  logic [CW-1:0] fCdr;
  logic          cdrLoad;
  logic          cdrAck;
  logic          cdrErr;
  logic          txSelect;
  logic          loopbackEnable;
  logic [ND-1:0] divEn;
  logic [ND*DW-1:0] divTc;
  logic          rxResync;
  logic          fastEnable;
  logic [ND-1:0] txTick;
  logic [ND-1:0] rxTick;

  typedef struct {
    logic          en;
    logic          load;
    logic [CW-1:0] fcdr;
    logic          expFe;
    logic          expAck;
    logic          expErr;
  } vec_t;

  vec_t vecs[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   lastTick, tickCount, feCount, found;
  logic prevFe, otherSeen, ackSeen;

  irda_fast_enable_gen_multi dut (
    .clk             (clk),
    .wb_rst_n        (wbRstN),
    .enable          (enable),
    .f_cdr           (fCdr),
    .cdr_load        (cdrLoad),
    .cdr_ack         (cdrAck),
    .cdr_err         (cdrErr),
    .tx_select       (txSelect),
    .loopback_enable (loopbackEnable),
    .div_en          (divEn),
    .div_tc          (divTc),
    .rx_resync       (rxResync),
    .fast_enable     (fastEnable),
    .tx_tick         (txTick),
    .rx_tick         (rxTick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic clockStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    enable  = v.en;
    cdrLoad = v.load;
    fCdr    = v.fcdr;
  endtask

  task automatic addVec(input logic en, input logic load, input int fcdr,
                        input logic fe, input logic ack, input logic err);
    vec_t v;
    v.en = en; v.load = load; v.fcdr = CW'(fcdr);
    v.expFe = fe; v.expAck = ack; v.expErr = err;
    vecs.push_back(v);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".fe"},  fastEnable, 0);
    checkOutput({tag, ".ack"}, cdrAck, 0);
    checkOutput({tag, ".err"}, cdrErr, 0);
    checkOutput({tag, ".tx"},  txTick, 0);
    checkOutput({tag, ".rx"},  rxTick, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Period 5 from reset, then load 2.5, reject 1.0, disabled load, back-to-back loads.
    for (int k = 1; k <= 4; k++) addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 0);
    for (int k = 6; k <= 9; k++) addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 1, 250000, 0, 0, 0);
    for (int k = 12; k <= 14; k++) addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 1, 100000, 0, 0, 1);
    addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(0, 1, 500000, 0, 1, 0);
    for (int k = 32; k <= 35; k++) addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 0);
    addVec(1, 1, 300000, 0, 0, 0);
    for (int k = 38; k <= 40; k++) addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 1, 200000, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0); addVec(1, 0, 0, 1, 0, 0);
    addVec(0, 1, 500000, 0, 1, 0);

    wbRstN = 1'b0; enable = 1'b0; fCdr = '0; cdrLoad = 1'b0;
    txSelect = 1'b1; loopbackEnable = 1'b0; divEn = '0; divTc = '0; rxResync = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    wbRstN = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      clockStep();
      checkOutput($sformatf("vec%0d.fe", i + 1), fastEnable, vecs[i].expFe);
      checkOutput($sformatf("vec%0d.ack", i + 1), cdrAck, vecs[i].expAck);
      checkOutput($sformatf("vec%0d.err", i + 1), cdrErr, vecs[i].expErr);
    end
    cdrLoad = 1'b0;

    // TX channel 0 at tc=4: one tick per 25 clocks, one cycle after a base tick.
    divTc = '0; divTc[3:0] = 4'd4; divEn = 3'b001; txSelect = 1'b1; loopbackEnable = 1'b0;
    enable = 1'b1;
    lastTick = -1; tickCount = 0; prevFe = 1'b0; otherSeen = 1'b0;
    for (int n = 0; n < 110; n++) begin
      clockStep();
      if (txTick[0]) begin
        checkOutput("txLatency", prevFe, 1);
        if (lastTick >= 0) checkOutput("txPeriod", n - lastTick, 25);
        lastTick = n; tickCount++;
      end
      otherSeen |= (txTick[2:1] != 0) || (rxTick != 0);
      prevFe = fastEnable;
    end
    checkOutput("txCountAtLeast4", tickCount >= 4, 1);
    checkOutput("txOnlyNoOthers", otherSeen, 0);

    loopbackEnable = 1'b1;
    lastTick = -1; tickCount = 0;
    for (int n = 0; n < 110; n++) begin
      clockStep();
      if (rxTick[0]) begin
        if (lastTick >= 0) checkOutput("rxLoopPeriod", n - lastTick, 25);
        lastTick = n; tickCount++;
      end
    end
    checkOutput("rxLoopCountAtLeast4", tickCount >= 4, 1);

    // tc=9, resync on the base tick that would have produced an RX tick.
    divTc[3:0] = 4'd9;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      clockStep();
      if (rxTick[0]) found = 1;
    end
    checkOutput("rxFirstTickSeen", found, 1);
    feCount = 0;
    for (int n = 0; n < 100 && feCount < 10; n++) begin
      clockStep();
      if (fastEnable) feCount++;
    end
    checkOutput("feBeforeResync", feCount, 10);
    rxResync = 1'b1;
    clockStep();
    rxResync = 1'b0;
    checkOutput("resyncSuppress", rxTick[0], 0);
    feCount = 0; found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      clockStep();
      if (rxTick[0]) found = 1;
      else if (fastEnable) feCount++;
    end
    checkOutput("resyncTickSeen", found, 1);
    checkOutput("resyncBaseTicks", feCount, 5);
    found = 0; lastTick = 0;
    for (int n = 1; n <= 120 && found == 0; n++) begin
      clockStep();
      if (rxTick[0]) begin found = 1; lastTick = n; end
    end
    checkOutput("resyncPeriodClocks", lastTick, 50);

    // Async reset with ticks high and a load pending.
    divTc = '0; divEn = 3'b111; loopbackEnable = 1'b1;
    repeat (60) clockStep();
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      clockStep();
      if (fastEnable) found = 1;
    end
    checkOutput("preResetFeSeen", found, 1);
    cdrLoad = 1'b1; fCdr = CW'(300000);
    clockStep();
    cdrLoad = 1'b0;
    checkOutput("preResetTx", txTick, 7);
    checkOutput("preResetRx", rxTick, 7);
    wbRstN = 1'b0;
    #1;
    checkAllZero("midReset");
    divEn = '0; loopbackEnable = 1'b0; enable = 1'b1;
    @(negedge clk);
    wbRstN = 1'b1;
    ackSeen = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      clockStep();
      checkOutput($sformatf("postReset%0d.fe", n), fastEnable, (n % 5 == 0) ? 1 : 0);
      ackSeen |= cdrAck;
    end
    checkOutput("postResetNoAck", ackSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
